// File: rtl/iiitb_imem_loader.sv
// Framed byte-stream loader: SYNC_BYTE, COUNT, COUNT*4 little-endian payload bytes, then an
// optional XOR checksum byte (enabled by defining LOADER_CSUM_EN); holds the core until loaded.
module iiitb_imem_loader #(
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              RN,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam int CAPACITY = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic              rx_ready_d, imem_we_d, core_hold_d, done_d, err_d;
    logic [ADDR_W-1:0] imem_addr_d;
    logic [31:0]       imem_wdata_d;
    logic              accept;
`ifdef LOADER_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign accept = rx_valid & rx_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        rx_ready_d   = 1'b1;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        core_hold_d  = core_hold;
        done_d       = done;
        err_d        = err;
`ifdef LOADER_CSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d     = S_COUNT;
                    core_hold_d = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    imem_addr_d = '0;
                    word_cnt_d  = '0;
                    byte_cnt_d  = '0;
`ifdef LOADER_CSUM_EN
                    csum_d      = '0;
`endif
                end
            end

            S_COUNT: begin
                if (accept) begin
                    n_d = rx_data;
                    if ({24'd0, rx_data} > 32'(CAPACITY)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (rx_data == 8'd0) begin
`ifdef LOADER_CSUM_EN
                        state_d     = S_CSUM;
`else
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    word_d     = {rx_data, word_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    // Fourth byte completes the word: strobe it out and pause the stream.
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {rx_data, word_q};
                        rx_ready_d   = 1'b0;
                        state_d      = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                imem_addr_d = imem_addr + ADDR_W'(1);
                word_cnt_d  = word_cnt_q + 8'd1;
                if (word_cnt_q + 8'd1 == n_q) begin
`ifdef LOADER_CSUM_EN
                    state_d     = S_CSUM;
`else
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    core_hold_d = 1'b0;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end

`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            rx_ready   <= rx_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            core_hold  <= core_hold_d;
            done       <= done_d;
            err        <= err_d;
`ifdef LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_iiitb_imem_loader.sv
// Self-checking bench for iiitb_imem_loader: directed frames plus random frames compared
// against a frame-level model of IMEM contents and status flags.
module tb_iiitb_imem_loader;

    localparam int         ADDR_W = 5;
    localparam int         CAP    = 1 << ADDR_W;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic              clk = 1'b0;
    logic              RN  = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    iiitb_imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .RN(RN), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] dut_mem   [CAP];
    logic [31:0] model_mem [CAP];
    logic [31:0] frame_words [256];
    logic [7:0]  frame_q [$];
    int          wr_addr_q [$];
    int          we_count = 0;
    int          rdy_bad  = 0;
    logic        armed;

    always @(posedge clk or negedge RN)
        if (!RN) armed <= 1'b0;
        else     armed <= 1'b1;

    // Capture IMEM writes and watch the ready/write-strobe relationship.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            dut_mem[imem_addr] = imem_wdata;
            we_count++;
            wr_addr_q.push_back(int'(imem_addr));
        end
        if (RN && armed && (rx_ready !== ~imem_we)) rdy_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        check({tag, "_core_hold"},  32'(core_hold),  32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("handshake_bound", 32'(guard < 50), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic build_frame(input int n, input logic [7:0] csum_xor);
        logic [7:0] x = 8'h00;
        frame_q.delete();
        frame_q.push_back(SYNC);
        frame_q.push_back(8'(n));
        if (n <= CAP) begin
            for (int i = 0; i < n; i++)
                for (int k = 0; k < 4; k++) begin
                    frame_q.push_back(8'(frame_words[i] >> (8 * k)));
                    x ^= 8'(frame_words[i] >> (8 * k));
                end
`ifdef LOADER_CSUM_EN
            frame_q.push_back(x ^ csum_xor);
`endif
        end
    endtask

    // Payload words land in IMEM whenever the count is legal, whatever the checksum says.
    task automatic apply_model(input int n);
        if (n <= CAP)
            for (int i = 0; i < n; i++) model_mem[i] = frame_words[i];
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame_q[i]) send_byte(frame_q[i], int'($urandom_range(0, gap_max)));
    endtask

    task automatic finish_check(input string tag, input int n, input logic [7:0] csum_xor,
                                input int we_before);
        logic exp_err;
        int   g = 0;
        int   bad = 0;
        exp_err = (n > CAP);
`ifdef LOADER_CSUM_EN
        if (n <= CAP && csum_xor != 8'h00) exp_err = 1'b1;
`endif
        while (!(done === 1'b1 || err === 1'b1) && g < 8) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check({tag, "_done"},      32'(done),      32'(!exp_err));
        check({tag, "_err"},       32'(err),       32'(exp_err));
        check({tag, "_core_hold"}, 32'(core_hold), 32'(exp_err));
        check({tag, "_writes"},    32'(we_count - we_before), 32'((n > CAP) ? 0 : n));
        if (n <= CAP) begin
            if (wr_addr_q.size() != n) bad++;
            else foreach (wr_addr_q[i]) if (wr_addr_q[i] != i) bad++;
        end
        check({tag, "_addr_order"}, 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < CAP; i++) if (dut_mem[i] !== model_mem[i]) bad++;
        check({tag, "_imem"}, 32'(bad), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int n, input logic [7:0] csum_xor,
                             input int gap_max);
        int we_before = we_count;
        wr_addr_q.delete();
        build_frame(n, csum_xor);
        apply_model(n);
        send_frame(gap_max);
        finish_check(tag, n, csum_xor, we_before);
    endtask

    task automatic random_words(input int n);
        for (int i = 0; i < n; i++) frame_words[i] = $urandom;
    endtask

    initial begin
        int we_before;
        for (int i = 0; i < CAP; i++) begin
            dut_mem[i]   = 32'h0;
            model_mem[i] = 32'h0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        RN = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(rx_ready), 32'd1);

        // Case 1: two-word program, with exact core_hold release timing
        frame_words[0] = 32'h002080b3;
        frame_words[1] = 32'h40208033;
        we_before = we_count;
        wr_addr_q.delete();
        build_frame(2, 8'h00);
        apply_model(2);
        send_frame(0);
`ifdef LOADER_CSUM_EN
        check("t1_hold_after_csum", 32'(core_hold), 32'd0);
        check("t1_done_after_csum", 32'(done), 32'd1);
`else
        check("t1_we_last",       32'(imem_we),   32'd1);
        check("t1_addr_last",     32'(imem_addr), 32'd1);
        check("t1_wdata_last",    imem_wdata,     32'h40208033);
        check("t1_hold_in_write", 32'(core_hold), 32'd1);
        @(negedge clk);
        check("t1_hold_released", 32'(core_hold), 32'd0);
`endif
        finish_check("t1", 2, 8'h00, we_before);
        check("t1_mem0", dut_mem[0], 32'h002080b3);
        check("t1_mem1", dut_mem[1], 32'h40208033);

        // Case 2: stray bytes before the frame are dropped
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 0);
        random_words(1);
        run_frame("t2", 1, 8'h00, 0);

`ifdef LOADER_CSUM_EN
        // Case 3: checksum mismatch, then recovery with a valid frame
        frame_words[0] = 32'h00000063;
        run_frame("t3_bad", 1, 8'h63, 0);
        random_words(2);
        run_frame("t3_good", 2, 8'h00, 1);
`endif

        // Case 4: count overflow, then a full-capacity frame
        run_frame("t4_over", CAP + 1, 8'h00, 0);
        random_words(CAP);
        run_frame("t4_full", CAP, 8'h00, 0);

        // Case 5: case-1 program with random valid gaps
        frame_words[0] = 32'h002080b3;
        frame_words[1] = 32'h40208033;
        run_frame("t5", 2, 8'h00, 4);
        check("t5_mem0", dut_mem[0], 32'h002080b3);
        check("t5_mem1", dut_mem[1], 32'h40208033);

        // Case 6: asynchronous reset after the 5th payload byte
        random_words(2);
        build_frame(2, 8'h00);
        for (int i = 0; i < 7; i++) send_byte(frame_q[i], 0);
        model_mem[0] = frame_words[0];
        #2 RN = 1'b0;
        #1 check_reset_outputs("t6_async");
        repeat (2) @(negedge clk);
        RN = 1'b1;
        @(negedge clk);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        random_words(3);
        run_frame("t6_reload", 3, 8'h00, 2);

        // Random frames, occasionally oversized or with a corrupted checksum
        for (int f = 0; f < 8; f++) begin
            int n;
            logic [7:0] cx;
            n  = int'($urandom_range(0, CAP + 3));
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            random_words(n <= CAP ? n : 0);
            run_frame($sformatf("rand%0d", f), n, cx, 3);
        end

        check("ready_low_only_on_write", 32'(rdy_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
